// File: rtl/usb_tx_line_encoder.sv
// Full-speed USB transmit line encoder: bit stuffing, NRZI, EOP generation.
// Optional SYNC generation is enabled by defining USB_TX_SYNC_GEN_EN.
module usb_tx_line_encoder #(
    parameter int CLKS_PER_BIT = 8,
    parameter int STUFF_LIMIT  = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic tx_start,
    input  logic tx_bit,
    input  logic tx_last,
    input  logic bit_valid,
    output logic bit_req,
    output logic d_plus,
    output logic d_minus,
    output logic tx_busy,
    output logic eop_done,
    output logic tx_underrun
);

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        STUFF,
        EOP_SE0,
        EOP_J
    } state_t;

    localparam int TW = $clog2(2 * CLKS_PER_BIT);
    localparam int OW = $clog2(STUFF_LIMIT + 1);

    localparam logic [TW-1:0] T_BIT_END = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] T_SE0_END = TW'(2 * CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] T_J_END   = TW'(CLKS_PER_BIT);
    localparam logic [OW-1:0] ONES_MAX  = OW'(STUFF_LIMIT);

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [OW-1:0]   ones_q, ones_d;
    logic            level_q, level_d;
    logic            last_q, last_d;
    logic            dp_q, dp_d;
    logic            dm_q, dm_d;
    logic            take;
    logic            data_bit;
    logic            sample;

`ifdef USB_TX_SYNC_GEN_EN
    logic [3:0]      sync_q, sync_d;
`endif

    assign sample  = (timer_q == '0);
    assign d_plus  = dp_q;
    assign d_minus = dm_q;
    assign tx_busy = (state_q != IDLE);

    // Line-state register; the line is updated at the end of each
    // sample cycle so a symbol holds for a full bit period after it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            ones_q  <= '0;
            level_q <= 1'b1;
            last_q  <= 1'b0;
            dp_q    <= 1'b1;
            dm_q    <= 1'b0;
`ifdef USB_TX_SYNC_GEN_EN
            sync_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            ones_q  <= ones_d;
            level_q <= level_d;
            last_q  <= last_d;
            dp_q    <= dp_d;
            dm_q    <= dm_d;
`ifdef USB_TX_SYNC_GEN_EN
            sync_q  <= sync_d;
`endif
        end
    end

    // Next-state, bit timing, stuffing and NRZI level selection.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q + TW'(1);
        ones_d      = ones_q;
        level_d     = level_q;
        last_d      = last_q;
        dp_d        = dp_q;
        dm_d        = dm_q;
        bit_req     = 1'b0;
        eop_done    = 1'b0;
        tx_underrun = 1'b0;
        take        = 1'b0;
        data_bit    = 1'b0;
`ifdef USB_TX_SYNC_GEN_EN
        sync_d      = sync_q;
`endif
        case (state_q)
            IDLE: begin
                timer_d = '0;
                level_d = 1'b1;
                dp_d    = 1'b1;
                dm_d    = 1'b0;
                if (tx_start) begin
                    state_d = DATA;
                    ones_d  = '0;
                    last_d  = 1'b0;
`ifdef USB_TX_SYNC_GEN_EN
                    sync_d  = '0;
`endif
                end
            end
            DATA: begin
                if (sample) begin
`ifdef USB_TX_SYNC_GEN_EN
                    if (sync_q != 4'd8) begin
                        take     = 1'b1;
                        data_bit = (sync_q == 4'd7);
                        sync_d   = sync_q + 4'd1;
                    end else
`endif
                    if (bit_valid) begin
                        take     = 1'b1;
                        data_bit = tx_bit;
                        bit_req  = 1'b1;
                        last_d   = tx_last;
                    end else begin
                        // Underrun aborts the packet; the SE0 period
                        // starts now, so this cycle counts as its first.
                        tx_underrun = 1'b1;
                        state_d     = EOP_SE0;
                        timer_d     = TW'(1);
                        ones_d      = '0;
                        dp_d        = 1'b0;
                        dm_d        = 1'b0;
                    end
                    if (take) begin
                        level_d = data_bit ? level_q : ~level_q;
                        dp_d    = level_d;
                        dm_d    = ~level_d;
                        ones_d  = data_bit ? ones_q + OW'(1) : '0;
                    end
                end else if (timer_q == T_BIT_END) begin
                    timer_d = '0;
                    if (ones_q == ONES_MAX) begin
                        state_d = STUFF;
                    end else if (last_q) begin
                        state_d = EOP_SE0;
                    end
                end
            end
            STUFF: begin
                if (sample) begin
                    level_d = ~level_q;
                    dp_d    = ~level_q;
                    dm_d    = level_q;
                    ones_d  = '0;
                end else if (timer_q == T_BIT_END) begin
                    timer_d = '0;
                    state_d = last_q ? EOP_SE0 : DATA;
                end
            end
            EOP_SE0: begin
                if (sample) begin
                    dp_d = 1'b0;
                    dm_d = 1'b0;
                end else if (timer_q == T_SE0_END) begin
                    timer_d = '0;
                    state_d = EOP_J;
                end
            end
            EOP_J: begin
                if (sample) begin
                    level_d = 1'b1;
                    dp_d    = 1'b1;
                    dm_d    = 1'b0;
                end else if (timer_q == T_J_END) begin
                    // J has now been on the line for a full bit period.
                    eop_done = 1'b1;
                    timer_d  = '0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_usb_tx_line_encoder.sv
// Testbench for usb_tx_line_encoder: per-cycle comparison against a
// symbol-level model of the packet on the bus.
module tb_usb_tx_line_encoder;

    localparam int CPB = 8;
    localparam int SL  = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx_start = 1'b0;
    logic tx_bit = 1'b0;
    logic tx_last = 1'b0;
    logic bit_valid = 1'b0;
    logic bit_req;
    logic d_plus;
    logic d_minus;
    logic tx_busy;
    logic eop_done;
    logic tx_underrun;

    int checks = 0;
    int errors = 0;

    logic       pkt_bits [0:63];
    logic [1:0] syms [$];
    bit         reqf [$];

    usb_tx_line_encoder #(
        .CLKS_PER_BIT(CPB),
        .STUFF_LIMIT (SL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_start   (tx_start),
        .tx_bit     (tx_bit),
        .tx_last    (tx_last),
        .bit_valid  (bit_valid),
        .bit_req    (bit_req),
        .d_plus     (d_plus),
        .d_minus    (d_minus),
        .tx_busy    (tx_busy),
        .eop_done   (eop_done),
        .tx_underrun(tx_underrun)
    );

    always #5 clk = ~clk;

    // Compare {d_plus,d_minus,bit_req,eop_done,tx_underrun,tx_busy}.
    task automatic check(input string tag, input int c,
                         input logic [5:0] exp);
        logic [5:0] obs;
        obs = {d_plus, d_minus, bit_req, eop_done, tx_underrun, tx_busy};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s c=%0d observed=%b expected=%b",
                   tag, c, obs, exp);
        end
    endtask

    // Bus symbols for one packet: NRZI with stuffing, then SE0 SE0 J.
    // u is the data-bit index at which bit_valid is dropped (-1: none).
    task automatic run_pkt(input string tag, input int n, input int u,
                           input bit poke);
        logic lvl;
        int ones;
        int us;
        int tot;
        int idx;
        bit got_req;
        logic b;
        logic [1:0] ln;
        logic [5:0] exp;
        int s;
        lvl = 1'b1;
        ones = 0;
        us = -1;
        syms.delete();
        reqf.delete();
`ifdef USB_TX_SYNC_GEN_EN
        for (int i = 0; i < 8; i++) begin
            b = (i == 7);
            if (!b) lvl = ~lvl;
            syms.push_back({lvl, ~lvl});
            reqf.push_back(1'b0);
            ones = b ? ones + 1 : 0;
        end
`endif
        for (int i = 0; i < n; i++) begin
            if (i == u) begin
                us = syms.size();
                break;
            end
            b = pkt_bits[i];
            if (!b) lvl = ~lvl;
            syms.push_back({lvl, ~lvl});
            reqf.push_back(1'b1);
            ones = b ? ones + 1 : 0;
            if (ones == SL) begin
                lvl = ~lvl;
                syms.push_back({lvl, ~lvl});
                reqf.push_back(1'b0);
                ones = 0;
            end
        end
        syms.push_back(2'b00);
        reqf.push_back(1'b0);
        syms.push_back(2'b00);
        reqf.push_back(1'b0);
        syms.push_back(2'b10);
        reqf.push_back(1'b0);
        tot = syms.size() * CPB;

        @(posedge clk);
        #1 tx_start = 1'b1;
        @(posedge clk);
        #1 tx_start = 1'b0;
        idx = 0;
        for (int c = -1; c <= tot; c++) begin
            tx_bit    = (idx < n) ? pkt_bits[idx] : 1'b0;
            tx_last   = (idx == n - 1);
            bit_valid = (idx < n) && (idx != u);
            tx_start  = poke && (c == 3 * CPB + 2);
            ln  = (c < 0 || c >= tot) ? 2'b10 : syms[c / CPB];
            s   = (c + 1) / CPB;
            exp = {ln,
                   ((c + 1) % CPB == 0) && s < syms.size() && reqf[s],
                   c == tot - 1,
                   us >= 0 && c == us * CPB - 1,
                   c < tot};
            @(negedge clk);
            check(tag, c, exp);
            got_req = bit_req;
            @(posedge clk);
            #1;
            if (got_req) idx++;
        end
        tx_start  = 1'b0;
        bit_valid = 1'b0;
    endtask

    initial begin
        int n;
        int u;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_state", 0, 6'b100000);

        // Reset while idle.
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check("rst_idle", 0, 6'b100000);
        @(posedge clk);
        #1 rst = 1'b0;

        // Reset mid-DATA with zero bits so the line sits at K.
        bit_valid = 1'b1;
        tx_bit    = 1'b0;
        @(posedge clk);
        #1 tx_start = 1'b1;
        @(posedge clk);
        #1 tx_start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("pre_rst_k", 0, 6'b010001);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check("rst_data", 0, 6'b100000);
        @(posedge clk);
        #1 rst = 1'b0;
        bit_valid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            check("post_rst_idle", c, 6'b100000);
        end

        // Eight zeros.
        for (int i = 0; i < 8; i++) pkt_bits[i] = 1'b0;
        run_pkt("zeros8", 8, -1, 1'b0);

        // Seven ones: stuff after the sixth.
        for (int i = 0; i < 7; i++) pkt_bits[i] = 1'b1;
        run_pkt("ones7", 7, -1, 1'b0);

        // Six ones, last on sixth: stuff precedes EOP.
        run_pkt("ones6", 6, -1, 1'b0);

        // Underrun at the third sample point.
        for (int i = 0; i < 6; i++) pkt_bits[i] = 1'($urandom_range(0, 1));
        run_pkt("underrun3", 6, 2, 1'b0);

        // tx_start pulsed mid-packet is ignored.
        for (int i = 0; i < 10; i++) pkt_bits[i] = 1'($urandom_range(0, 1));
        run_pkt("start_ignored", 10, -1, 1'b1);

        // Randomized packets, biased towards ones to exercise stuffing.
        for (int p = 0; p < 12; p++) begin
            n = $urandom_range(1, 24);
            for (int i = 0; i < n; i++)
                pkt_bits[i] = ($urandom_range(0, 3) != 0);
            u = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
            run_pkt("random", n, u, 1'b0);
            repeat ($urandom_range(0, 5)) @(posedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
